lsu_dmem_master: RTL and testbench
==================================

Name: lsu_dmem_master

Overview:
Load/store initiator that drives the data-memory port (Addr, MemRW, DataW, whb, DataR) on behalf of the core's memory stage. It accepts one RISC-V load/store per handshake and translates funct3 to the memory's whb encoding. Misaligned word accesses are split into two halfword accesses, because the memory handles misaligned halfwords but not misaligned words. The memory has registered read data: the address is presented, then held a second cycle while DataR is captured.

Parameters:
DMEM_WORDS, 20001, memory depth in 32-bit words; any access touching byte address >= DMEM_WORDS*4 is an error.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  load result, extended per funct3; 0 for stores/errors
rsp_err  out  1  qualified by rsp_valid: illegal funct3 or out-of-range
Addr  out  32  memory byte address
MemRW  out  1  memory write enable
DataW  out  32  memory write data
whb  out  3  memory size code (000 sb/lb, 001 sh/lh, 010 w, 011 lbu, 100 lhu)
DataR  in  32  memory read data, valid the cycle after Addr/whb are presented and while they are held

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: state IDLE, Addr=0, MemRW=0, DataW=0, whb=3'b010, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=0 while rst_n=0.
- All memory-side outputs are registered. req_ready = (state==IDLE) && rst_n.
- States:
  - IDLE: on handshake, latch we/funct3/addr/wdata; split = (funct3==010 && addr[1:0]!=0).
    - Illegal request (load funct3 011/110/111; store funct3 not in 000/001/010; range violation) -> RESP with err=1, no memory access.
    - Otherwise -> ACC0.
  - ACC0: Addr=addr, MemRW=we.
    - whb: the translated code; if split, 100 for loads, 001 for stores.
    - DataW: wdata, or {16'b0, wdata[15:0]} if split.
    - Store -> ACC1 if split, else RESP. Load -> DAT0.
  - DAT0: hold Addr/whb, MemRW=0, capture DataR into lo. -> ACC1 if split, else RESP.
  - ACC1 (split only): Addr=addr+2; whb=100 for loads, 001 for stores; DataW={16'b0, wdata[31:16]}. Load -> DAT1, store -> RESP.
  - DAT1: hold, MemRW=0, capture DataR into hi. -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle; rsp_rdata = {hi[15:0], lo[15:0]} if split, else lo; 0 for stores. -> IDLE.
- MemRW is 1 for exactly one cycle per write access and is 0 in every other state.
- Latency from the accept cycle T to rsp_valid:
  - aligned/halfword/byte load: T+3
  - store: T+2
  - split load: T+5
  - split store: T+3
  - error: T+1
- Halfword at offset 3 is issued as a single access; the memory crosses the word boundary itself.
- funct3 to whb: 000->000, 001->001, 010->010, 100->011, 101->100.
- Range check: addr + size - 1 >= DMEM_WORDS*4 -> error. The check is computed with 33-bit arithmetic, so there is no wrap at 0xFFFFFFFF.
- No response backpressure; the next request is accepted the cycle after RESP.
- Reset mid-operation: the transaction is abandoned and no rsp_valid is produced. MemRW=0 from the reset edge; a write already issued stays committed.

Optional Feature:
LSU_MISALIGN_TRAP_EN:
- Defined: a misaligned word access (addr[1:0]!=0, funct3 010), or a misaligned halfword (addr[0]=1), is not issued; the block goes straight to RESP with rsp_err=1 at T+1. ACC1/DAT1 are unreachable.
- Undefined: the split behaviour described above; no alignment errors.

Test Plan:
- Preload word[1]=0x88776655, word[2]=0xCCBBAA99; lb at 0x7 -> rsp_rdata=0xFFFFFF88 at T+3; lbu at 0x7 -> 0x00000088.
- Aligned lw at 0x4 -> 0x88776655 at T+3; lh at 0x7 (crosses word) -> single access with whb=001, rsp_rdata=0xFFFF9988.
- Misaligned lw at 0x5 -> two accesses, Addr=0x5 then 0x7, whb=100 both; rsp_rdata=0x99887766 at T+5, rsp_err=0.
- sw 0xDEADBEEF at 0x6 -> sh 0xBEEF at 0x6, then sh 0xDEAD at 0x8; afterwards word[1]=0xBEEF6655, word[2]=0xCCBBDEAD; rsp_valid at T+3.
- Load with funct3=011 -> rsp_valid at T+1 with rsp_err=1, MemRW never 1; lw at address DMEM_WORDS*4-2 -> rsp_err=1.
- rst_n=0 during DAT0 of a split load -> no rsp_valid; req_ready=1 the cycle after rst_n returns high; outputs at reset values.

Source files
------------

// File: rtl/lsu_dmem_master_if.sv
// lsu_dmem_master_if: request/response handshake and data-memory port of the
// load/store initiator. The master modport is the initiator's view; the slave
// modport is the view of whoever drives requests and models the memory.
interface lsu_dmem_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] Addr;
   logic        MemRW;
   logic [31:0] DataW;
   logic [2:0]  whb;
   logic [31:0] DataR;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, DataR,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, Addr, MemRW, DataW, whb
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, DataR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, Addr, MemRW, DataW, whb
   );
endinterface

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: drives the data-memory port for one RISC-V load/store at a
// time. Misaligned words are split into two halfword accesses; the memory
// returns read data one cycle after the address, so each read holds Addr/whb
// for a second cycle. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned
// word/halfword accesses into error responses instead of splitting them.
module lsu_dmem_master #(
   parameter int unsigned DMEM_WORDS = 32'd20001
) (
   input  logic              clk,
   input  logic              rst_n,
   lsu_dmem_master_if.master bus
);
   localparam logic [32:0] DMEM_BYTES = 33'(DMEM_WORDS) * 33'd4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACC0 = 3'd1,
      DAT0 = 3'd2,
      ACC1 = 3'd3,
      DAT1 = 3'd4,
      RESP = 3'd5
   } state_t;

   // Access size in bytes for a funct3 code.
   function automatic logic [2:0] acc_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // RISC-V funct3 to memory size code.
   function automatic logic [2:0] to_whb(input logic [2:0] f3);
      case (f3)
         3'b000:  return 3'b000;
         3'b001:  return 3'b001;
         3'b100:  return 3'b011;
         3'b101:  return 3'b100;
         default: return 3'b010;
      endcase
   endfunction

   function automatic logic is_illegal(input logic we, input logic [2:0] f3);
      if (we) begin
         return !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010));
      end else begin
         return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
   endfunction

   // 33-bit last-byte address so an access near 0xFFFFFFFF cannot wrap.
   function automatic logic out_of_range(input logic [31:0] a, input logic [2:0] f3);
      logic [32:0] last_byte;
      last_byte = {1'b0, a} + {30'd0, acc_size(f3)} - 33'd1;
      return last_byte >= DMEM_BYTES;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [31:0] a, input logic [2:0] f3);
      return ((f3 == 3'b010) && (a[1:0] != 2'b00)) || ((f3[1:0] == 2'b01) && a[0]);
   endfunction
`endif

   // Sign/zero extension of a single-access load result.
   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'b000:  return {{24{d[7]}}, d[7:0]};
         3'b001:  return {{16{d[15]}}, d[15:0]};
         3'b100:  return {24'd0, d[7:0]};
         3'b101:  return {16'd0, d[15:0]};
         default: return d;
      endcase
   endfunction

   state_t      state_r, state_nx_s;
   logic        we_r, we_nx_s;
   logic [2:0]  funct3_r, funct3_nx_s;
   logic [31:0] addr_r, addr_nx_s;
   logic [31:0] wdata_r, wdata_nx_s;
   logic        split_r, split_nx_s;
   logic [15:0] lo_r, lo_nx_s;
   logic [31:0] mem_addr_r, mem_addr_nx_s;
   logic        mem_rw_r, mem_rw_nx_s;
   logic [31:0] mem_wdata_r, mem_wdata_nx_s;
   logic [2:0]  whb_r, whb_nx_s;
   logic        rsp_valid_r, rsp_valid_nx_s;
   logic [31:0] rsp_rdata_r, rsp_rdata_nx_s;
   logic        rsp_err_r, rsp_err_nx_s;
   logic        req_bad_s;
   logic        req_split_s;

   // Classify the incoming request: rejected outright, or split into halves.
   always_comb begin
      req_bad_s = is_illegal(bus.req_we, bus.req_funct3) ||
                  out_of_range(bus.req_addr, bus.req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
      req_bad_s   = req_bad_s || is_misaligned(bus.req_addr, bus.req_funct3);
      req_split_s = 1'b0;
`else
      req_split_s = (bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00);
`endif
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_nx_s     = state_r;
      we_nx_s        = we_r;
      funct3_nx_s    = funct3_r;
      addr_nx_s      = addr_r;
      wdata_nx_s     = wdata_r;
      split_nx_s     = split_r;
      lo_nx_s        = lo_r;
      mem_addr_nx_s  = mem_addr_r;
      mem_rw_nx_s    = 1'b0;
      mem_wdata_nx_s = mem_wdata_r;
      whb_nx_s       = whb_r;
      rsp_valid_nx_s = 1'b0;
      rsp_rdata_nx_s = 32'd0;
      rsp_err_nx_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.req_valid) begin
               we_nx_s     = bus.req_we;
               funct3_nx_s = bus.req_funct3;
               addr_nx_s   = bus.req_addr;
               wdata_nx_s  = bus.req_wdata;
               split_nx_s  = req_split_s;
               if (req_bad_s) begin
                  state_nx_s     = RESP;
                  rsp_valid_nx_s = 1'b1;
                  rsp_err_nx_s   = 1'b1;
               end else begin
                  state_nx_s    = ACC0;
                  mem_addr_nx_s = bus.req_addr;
                  mem_rw_nx_s   = bus.req_we;
                  if (req_split_s) begin
                     whb_nx_s       = bus.req_we ? 3'b001 : 3'b100;
                     mem_wdata_nx_s = {16'd0, bus.req_wdata[15:0]};
                  end else begin
                     whb_nx_s       = to_whb(bus.req_funct3);
                     mem_wdata_nx_s = bus.req_wdata;
                  end
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         ACC0: begin
            if (!we_r) begin
               state_nx_s = DAT0;
            end else if (split_r) begin
               state_nx_s     = ACC1;
               mem_addr_nx_s  = addr_r + 32'd2;
               mem_rw_nx_s    = 1'b1;
               whb_nx_s       = 3'b001;
               mem_wdata_nx_s = {16'd0, wdata_r[31:16]};
            end else begin
               state_nx_s     = RESP;
               rsp_valid_nx_s = 1'b1;
            end
         end
         DAT0: begin
            lo_nx_s = bus.DataR[15:0];
            if (split_r) begin
               state_nx_s     = ACC1;
               mem_addr_nx_s  = addr_r + 32'd2;
               whb_nx_s       = 3'b100;
               mem_wdata_nx_s = {16'd0, wdata_r[31:16]};
            end else begin
               state_nx_s     = RESP;
               rsp_valid_nx_s = 1'b1;
               rsp_rdata_nx_s = load_extend(funct3_r, bus.DataR);
            end
         end
         ACC1: begin
            if (we_r) begin
               state_nx_s     = RESP;
               rsp_valid_nx_s = 1'b1;
            end else begin
               state_nx_s = DAT1;
            end
         end
         DAT1: begin
            state_nx_s     = RESP;
            rsp_valid_nx_s = 1'b1;
            rsp_rdata_nx_s = {bus.DataR[15:0], lo_r};
         end
         RESP: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         we_r        <= 1'b0;
         funct3_r    <= 3'b000;
         addr_r      <= 32'd0;
         wdata_r     <= 32'd0;
         split_r     <= 1'b0;
         lo_r        <= 16'd0;
         mem_addr_r  <= 32'd0;
         mem_rw_r    <= 1'b0;
         mem_wdata_r <= 32'd0;
         whb_r       <= 3'b010;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'd0;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         we_r        <= we_nx_s;
         funct3_r    <= funct3_nx_s;
         addr_r      <= addr_nx_s;
         wdata_r     <= wdata_nx_s;
         split_r     <= split_nx_s;
         lo_r        <= lo_nx_s;
         mem_addr_r  <= mem_addr_nx_s;
         mem_rw_r    <= mem_rw_nx_s;
         mem_wdata_r <= mem_wdata_nx_s;
         whb_r       <= whb_nx_s;
         rsp_valid_r <= rsp_valid_nx_s;
         rsp_rdata_r <= rsp_rdata_nx_s;
         rsp_err_r   <= rsp_err_nx_s;
      end
   end

   assign bus.req_ready = (state_r == IDLE) && rst_n;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_err   = rsp_err_r;
   assign bus.Addr      = mem_addr_r;
   assign bus.MemRW     = mem_rw_r;
   assign bus.DataW     = mem_wdata_r;
   assign bus.whb       = whb_r;
endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: directed test-plan steps followed by random requests,
// each checked against a byte-level reference model of load/store semantics.
module tb_lsu_dmem_master;
   localparam int unsigned DMEM_WORDS = 20001;
   localparam int NBYTES = DMEM_WORDS * 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   lsu_dmem_master_if bus();

   lsu_dmem_master #(.DMEM_WORDS(DMEM_WORDS)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem     [0:NBYTES-1];
   logic [7:0]  ref_mem [0:NBYTES-1];
   logic        bd_we = 1'b0;
   int          bd_byte = 0;
   logic [31:0] bd_word = 32'd0;
   int          checks = 0;
   int          failures = 0;

   // per-cycle trace of the most recent transaction (index = cycles after accept)
   logic [31:0] s_addr [0:15];
   logic [2:0]  s_whb  [0:15];
   logic        s_rw   [0:15];
   logic [31:0] s_dw   [0:15];
   logic [31:0] last_rdata;
   logic        last_err;

   function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] w);
      logic [31:0] raw;
      raw = 32'd0;
      for (int i = 0; i < 4; i++)
         if (longint'(a) + i < NBYTES) raw[8*i +: 8] = mem[longint'(a) + i];
      case (w)
         3'b000:  return {{24{raw[7]}}, raw[7:0]};
         3'b001:  return {{16{raw[15]}}, raw[15:0]};
         3'b011:  return {24'd0, raw[7:0]};
         3'b100:  return {16'd0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   // Data memory: writes on MemRW, read data registered one cycle after Addr.
   always @(posedge clk) begin
      if (bd_we) begin
         for (int i = 0; i < 4; i++) mem[bd_byte + i] <= bd_word[8*i +: 8];
      end else if (bus.MemRW) begin
         for (int i = 0; i < ((bus.whb == 3'b000) ? 1 : (bus.whb == 3'b001) ? 2 : 4); i++)
            if (longint'(bus.Addr) + i < NBYTES) mem[longint'(bus.Addr) + i] <= bus.DataW[8*i +: 8];
      end
      bus.DataR <= mem_read(bus.Addr, bus.whb);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " Addr"},      bus.Addr, 32'd0);
      check({tag, " MemRW"},     32'(bus.MemRW), 32'd0);
      check({tag, " DataW"},     bus.DataW, 32'd0);
      check({tag, " whb"},       32'(bus.whb), 32'd2);
      check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, " rsp_rdata"}, bus.rsp_rdata, 32'd0);
      check({tag, " rsp_err"},   32'(bus.rsp_err), 32'd0);
   endtask

   task automatic bd_write(input int word_idx, input logic [31:0] val);
      @(negedge clk);
      bd_we = 1'b1;
      bd_byte = word_idx * 4;
      bd_word = val;
      for (int i = 0; i < 4; i++) ref_mem[word_idx*4 + i] = val[8*i +: 8];
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   // Reference model: outcome of one request from the architectural rules.
   task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic err, output logic [31:0] rd,
                          output int lat, output int writes);
      int     size;
      logic   legal, bad, split;
      logic [31:0] v;
      size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      bad   = !legal || (longint'(a) + size - 1 >= longint'(NBYTES));
      split = (size == 4) && (a % 4 != 0);
`ifdef LSU_MISALIGN_TRAP_EN
      bad   = bad || (size == 4 && a % 4 != 0) || (size == 2 && a % 2 != 0);
      split = 1'b0;
`endif
      err = 1'b0; rd = 32'd0; lat = 1; writes = 0;
      if (bad) begin
         err = 1'b1;
      end else if (we) begin
         for (int i = 0; i < size; i++) ref_mem[longint'(a) + i] = wd[8*i +: 8];
         lat = split ? 3 : 2;
         writes = split ? 2 : 1;
      end else begin
         v = 32'd0;
         for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[longint'(a) + i];
         if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
         if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
         rd = v;
         lat = split ? 5 : 3;
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input string tag);
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat, e_wr, lat, wr;
      bit          got;
      predict(we, f3, a, wd, e_err, e_rd, e_lat, e_wr);
      @(negedge clk);
      check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, " rsp_idle"}, 32'(bus.rsp_valid), 32'd0);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = a; bus.req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1; got = 1'b0; wr = 0;
      last_rdata = 32'd0; last_err = 1'b0;
      while (!got && lat <= 12) begin
         s_addr[lat] = bus.Addr; s_whb[lat] = bus.whb;
         s_rw[lat] = bus.MemRW; s_dw[lat] = bus.DataW;
         if (bus.MemRW) wr++;
         if (bus.rsp_valid) begin
            got = 1'b1;
            last_rdata = bus.rsp_rdata;
            last_err = bus.rsp_err;
         end else begin
            @(negedge clk);
            lat++;
         end
      end
      check({tag, " latency"}, 32'(lat), 32'(e_lat));
      check({tag, " rsp_err"}, 32'(last_err), 32'(e_err));
      check({tag, " rsp_rdata"}, last_rdata, e_rd);
      check({tag, " write_cycles"}, 32'(wr), 32'(e_wr));
   endtask

   initial begin
      int          rsp_seen;
      logic [31:0] ra;
      int          r;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset req_ready", 32'(bus.req_ready), 32'd0);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      #1;
      check("post-reset req_ready", 32'(bus.req_ready), 32'd1);

      for (int w = 0; w < 64; w++) bd_write(w, $urandom());
      for (int w = DMEM_WORDS - 4; w < DMEM_WORDS; w++) bd_write(w, $urandom());
      bd_write(1, 32'h88776655);
      bd_write(2, 32'hCCBBAA99);

      do_req(1'b0, 3'b000, 32'h7, 32'h0, "lb_0x7");
      check("lb_0x7 value", last_rdata, 32'hFFFFFF88);
      do_req(1'b0, 3'b100, 32'h7, 32'h0, "lbu_0x7");
      check("lbu_0x7 value", last_rdata, 32'h00000088);
      check("lbu_0x7 whb", 32'(s_whb[1]), 32'd3);
      do_req(1'b0, 3'b010, 32'h4, 32'h0, "lw_0x4");
      check("lw_0x4 value", last_rdata, 32'h88776655);
      do_req(1'b0, 3'b001, 32'h7, 32'h0, "lh_0x7");
      check("lh_0x7 value", last_rdata, 32'hFFFF9988);
      check("lh_0x7 whb", 32'(s_whb[1]), 32'd1);
      check("lh_0x7 Addr", s_addr[1], 32'h7);
`ifndef LSU_MISALIGN_TRAP_EN
      do_req(1'b0, 3'b010, 32'h5, 32'h0, "lw_0x5");
      check("lw_0x5 value", last_rdata, 32'h99887766);
      check("lw_0x5 Addr0", s_addr[1], 32'h5);
      check("lw_0x5 whb0", 32'(s_whb[1]), 32'd4);
      check("lw_0x5 Addr1", s_addr[3], 32'h7);
      check("lw_0x5 whb1", 32'(s_whb[3]), 32'd4);
      do_req(1'b1, 3'b010, 32'h6, 32'hDEADBEEF, "sw_0x6");
      check("sw_0x6 Addr0", s_addr[1], 32'h6);
      check("sw_0x6 DataW0", s_dw[1], 32'h0000BEEF);
      check("sw_0x6 whb0", 32'(s_whb[1]), 32'd1);
      check("sw_0x6 Addr1", s_addr[2], 32'h8);
      check("sw_0x6 DataW1", s_dw[2], 32'h0000DEAD);
      check("sw_0x6 whb1", 32'(s_whb[2]), 32'd1);
      check("sw_0x6 word1", {mem[7], mem[6], mem[5], mem[4]}, 32'hBEEF6655);
      check("sw_0x6 word2", {mem[11], mem[10], mem[9], mem[8]}, 32'hCCBBDEAD);
`else
      do_req(1'b0, 3'b010, 32'h5, 32'h0, "lw_0x5_trap");
      do_req(1'b1, 3'b010, 32'h6, 32'hDEADBEEF, "sw_0x6_trap");
`endif
      do_req(1'b0, 3'b011, 32'h10, 32'h0, "ld_f3_011");
      check("ld_f3_011 err", 32'(last_err), 32'd1);
      do_req(1'b0, 3'b010, 32'(NBYTES - 2), 32'h0, "lw_top_minus2");
      check("lw_top_minus2 err", 32'(last_err), 32'd1);
      do_req(1'b0, 3'b010, 32'(NBYTES - 4), 32'h0, "lw_top_word");
      do_req(1'b1, 3'b100, 32'h20, 32'h12345678, "st_f3_100");
      do_req(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, "lb_wrap");

      // reset while the first half of a split load waits for read data
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h5; bus.req_wdata = 32'h0;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("midrst req_ready low", 32'(bus.req_ready), 32'd0);
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      #1;
      check("midrst req_ready high", 32'(bus.req_ready), 32'd1);
      rsp_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid) rsp_seen++;
      end
      check("midrst no rsp_valid", 32'(rsp_seen), 32'd0);
      check_reset_outputs("midrst idle");

      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         if (r < 7)      ra = 32'($urandom_range(0, 250));
         else if (r < 9) ra = 32'(NBYTES - 12 + $urandom_range(0, 15));
         else            ra = $urandom();
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom(), "rand");
      end

      @(negedge clk);
      for (int w = 0; w < 64; w++)
         check("mem low word", {mem[w*4+3], mem[w*4+2], mem[w*4+1], mem[w*4]},
               {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]});
      for (int w = DMEM_WORDS - 4; w < DMEM_WORDS; w++)
         check("mem top word", {mem[w*4+3], mem[w*4+2], mem[w*4+1], mem[w*4]},
               {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
